proc_core_param: RTL

PROC_CORE_PARAM -- requirements
Module: proc_core_param

---
 rtl/proc_pkg.sv | 55 +++++
 rtl/proc_core_param_regfile.sv | 36 +++
 rtl/proc_core_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the parameterised accumulator-style core:
// opcode and step encodings, instruction field offsets, control bundle.
package proc_pkg;

    // Opcodes 10-15 are reserved and execute as a one-step NOP.
    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9
    } op_e;

    // T0 is idle/fetch; T1..T3 are execute steps.
    typedef enum logic [1:0] {
        STEP_T0 = 2'd0,
        STEP_T1 = 2'd1,
        STEP_T2 = 2'd2,
        STEP_T3 = 2'd3
    } step_e;

    // Datapath load strobes produced by the sequencer each cycle.
    typedef struct packed {
        logic ld_ir;
        logic ld_a;
        logic ld_g;
        logic ld_flags;
        logic we;
    } ctrl_t;

    // Instruction layout: OP in the low nibble, RX above it, RY above RX.
    localparam int OP_LSB   = 0;
    localparam int OP_WIDTH = 4;
    localparam int RX_LSB   = 4;

    function automatic int ry_lsb(input int aw);
        return RX_LSB + aw;
    endfunction

    // Number of low IR bits that carry meaning; anything above is ignored.
    function automatic int ir_used(input int aw);
        return RX_LSB + 2 * aw;
    endfunction

    // ALU class: three execute steps through A and G.
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'(OP_ADD)) && (op <= 4'(OP_SHR));
    endfunction

endpackage

// File: rtl/proc_core_param_regfile.sv
// Register file: NREG x W, one synchronous write port, two combinational
// read ports. A write and a read of the same entry in one cycle returns the
// old contents until the clock edge.
module regfile_param #(
    parameter int W    = 10,
    parameter int NREG = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [NREG];

    // Reset clears every entry and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/proc_core_param.sv
// Multi-cycle register-machine core. A four-step sequencer (T0..T3) fetches
// an instruction word from Data on Start, then executes LOAD/MOV in one step
// or an ALU op through the A and G registers in three steps. Bus is a plain
// mux of the one active source each step.
module proc_core_param
    import proc_pkg::*;
#(
    parameter int W    = 10,
    parameter int NREG = 4
) (
    input  logic                    CLKb,
    input  logic                    RST,
    input  logic [W-1:0]            Data,
    input  logic                    Start,
    input  logic [$clog2(NREG)-1:0] PeekA,
    output logic [W-1:0]            PeekQ,
    output logic [W-1:0]            Bus,
    output logic [1:0]              T,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Zf,
    output logic                    Cf
);

    localparam int AW      = $clog2(NREG);
    localparam int RY_LSB  = ry_lsb(AW);
    localparam int IR_USED = ir_used(AW);

    // Elaboration-time sanity of the parameter set.
    if (NREG < 2 || (1 << AW) != NREG) begin : g_bad_nreg
        $error("proc_core_param: NREG must be a power of two and at least 2");
    end
    if (W < IR_USED) begin : g_bad_w
        $error("proc_core_param: W too narrow for opcode and two register fields");
    end

    step_e          step_q, step_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   ir_q, a_q, g_q;
    logic           g_carry_q;
    logic           zf_q, cf_q;

    logic [3:0]     op;
    logic [AW-1:0]  rx, ry;
    ctrl_t          ctrl;
    logic           sel_rx;
    logic           done;
    logic [W-1:0]   bus;
    logic [W-1:0]   wdata;
    logic [AW-1:0]  raddr_a;
    logic [W-1:0]   rf_a;
    logic [W-1:0]   alu_res;
    logic           alu_c;

    assign op = ir_q[OP_LSB +: OP_WIDTH];
    assign rx = ir_q[RX_LSB +: AW];
    assign ry = ir_q[RY_LSB +: AW];

    // High IR bits carry no meaning; keep them but mark them as unused.
    if (W > IR_USED) begin : g_ir_spare
        logic unused_ir_hi;
        assign unused_ir_hi = ^ir_q[W-1:IR_USED];
    end

    // Read port A serves R[RX] only at ALU-T1 (to load A); every other step
    // that needs a register wants R[RY]. Port B is dedicated to PeekA.
    assign sel_rx  = (step_q == STEP_T1) && is_alu(op);
    assign raddr_a = sel_rx ? rx : ry;

    regfile_param #(.W(W), .NREG(NREG)) u_rf (
        .clk     (CLKb),
        .rst     (RST),
        .we      (ctrl.we),
        .waddr   (rx),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (PeekA),
        .rdata_a (rf_a),
        .rdata_b (PeekQ)
    );

    // ALU: A op R[RY] at T2, with the carry/borrow/shifted-out bit alongside.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, rf_a};
            OP_SUB: {alu_c, alu_res} = {1'b0, a_q} - {1'b0, rf_a};
            OP_AND: alu_res = a_q & rf_a;
            OP_OR:  alu_res = a_q | rf_a;
            OP_XOR: alu_res = a_q ^ rf_a;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: {alu_c, alu_res} = {a_q, 1'b0};
            OP_SHR: {alu_res, alu_c} = {1'b0, a_q};
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // Sequencer next-state, bus source and datapath strobes for each step.
    always_comb begin
        step_d = step_q;
        busy_d = busy_q;
        ctrl   = '0;
        done   = 1'b0;
        bus    = '0;
        wdata  = '0;
        case (step_q)
            STEP_T0: begin
                bus = Data;
                if (Start) begin
                    ctrl.ld_ir = 1'b1;
                    busy_d     = 1'b1;
                    step_d     = STEP_T1;
                end
            end
            STEP_T1: begin
                if (op == 4'(OP_LOAD)) begin
                    bus     = Data;
                    wdata   = Data;
                    ctrl.we = 1'b1;
                    done    = 1'b1;
                end else if (op == 4'(OP_MOV)) begin
                    bus     = rf_a;
                    wdata   = rf_a;
                    ctrl.we = 1'b1;
                    done    = 1'b1;
                end else if (is_alu(op)) begin
                    bus       = rf_a;
                    ctrl.ld_a = 1'b1;
                end else begin
                    done = 1'b1;
                end
                if (done) begin
                    step_d = STEP_T0;
                    busy_d = 1'b0;
                end else begin
                    step_d = STEP_T2;
                end
            end
            STEP_T2: begin
                bus       = rf_a;
                ctrl.ld_g = 1'b1;
                step_d    = STEP_T3;
            end
            STEP_T3: begin
                bus           = g_q;
                wdata         = g_q;
                ctrl.we       = 1'b1;
                ctrl.ld_flags = 1'b1;
                done          = 1'b1;
                step_d        = STEP_T0;
                busy_d        = 1'b0;
            end
            default: begin
                step_d = STEP_T0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Step and busy state; reset aborts any instruction in flight.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            step_q <= STEP_T0;
            busy_q <= 1'b0;
        end else begin
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    // Datapath registers: IR on fetch, A at ALU-T1, G at T2, flags at T3.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            ir_q      <= '0;
            a_q       <= '0;
            g_q       <= '0;
            g_carry_q <= 1'b0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
        end else begin
            if (ctrl.ld_ir) ir_q <= Data;
            if (ctrl.ld_a)  a_q  <= rf_a;
            if (ctrl.ld_g) begin
                g_q       <= alu_res;
                g_carry_q <= alu_c;
            end
            if (ctrl.ld_flags) begin
                zf_q <= (g_q == '0);
                cf_q <= g_carry_q;
            end
        end
    end

    assign Bus  = bus;
    assign T    = step_q;
    assign Busy = busy_q;
    assign Done = done;
    assign Zf   = zf_q;
    assign Cf   = cf_q;

endmodule
